// File: rtl/riscv_multiplier_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_multiplier_pipe_pkg
// Description : M-extension multiply encodings, result-select codes and the
//               instruction decode helper shared by the multiplier pipe.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_multiplier_pipe_pkg;

  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_OP32   = 7'b0111011;
  localparam logic [6:0]  F7_MULDIV  = 7'b0000001;
  localparam logic [2:0]  F3_MUL     = 3'b000;
  localparam logic [2:0]  F3_MULH    = 3'b001;
  localparam logic [2:0]  F3_MULHSU  = 3'b010;
  localparam logic [2:0]  F3_MULHU   = 3'b011;

  // funct7 | funct3 | major opcode
  localparam logic [31:0] MASK_MUL     = 32'hFE00_707F;
  localparam logic [31:0] MATCH_MUL    = {F7_MULDIV, 10'b0, F3_MUL,    5'b0, OPC_OP};
  localparam logic [31:0] MATCH_MULH   = {F7_MULDIV, 10'b0, F3_MULH,   5'b0, OPC_OP};
  localparam logic [31:0] MATCH_MULHSU = {F7_MULDIV, 10'b0, F3_MULHSU, 5'b0, OPC_OP};
  localparam logic [31:0] MATCH_MULHU  = {F7_MULDIV, 10'b0, F3_MULHU,  5'b0, OPC_OP};
  localparam logic [31:0] MATCH_MULW   = {F7_MULDIV, 10'b0, F3_MUL,    5'b0, OPC_OP32};

  typedef enum logic [1:0] {
    SEL_LO = 2'd0,
    SEL_HI = 2'd1,
    SEL_W  = 2'd2
  } res_sel_e;

  typedef struct packed {
    logic     ok;
    res_sel_e sel;
    logic     sgn_a;
    logic     sgn_b;
  } mul_dec_t;

  // Classify an instruction word; MULW is only legal on a 64-bit datapath
  function automatic mul_dec_t mul_decode(input logic [31:0] insn, input logic rv64);
    mul_dec_t d;
    d.ok    = 1'b0;
    d.sel   = SEL_LO;
    d.sgn_a = 1'b0;
    d.sgn_b = 1'b0;
    if ((insn & MASK_MUL) == MATCH_MUL) begin
      d.ok = 1'b1;
    end else if ((insn & MASK_MUL) == MATCH_MULH) begin
      d.ok    = 1'b1;
      d.sel   = SEL_HI;
      d.sgn_a = 1'b1;
      d.sgn_b = 1'b1;
    end else if ((insn & MASK_MUL) == MATCH_MULHSU) begin
      d.ok    = 1'b1;
      d.sel   = SEL_HI;
      d.sgn_a = 1'b1;
    end else if ((insn & MASK_MUL) == MATCH_MULHU) begin
      d.ok  = 1'b1;
      d.sel = SEL_HI;
    end else if (rv64 && ((insn & MASK_MUL) == MATCH_MULW)) begin
      d.ok  = 1'b1;
      d.sel = SEL_W;
    end
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_multiplier_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : riscv_multiplier_pipe_if
// Description : Issue, control and writeback bundle of the multiplier pipe.
// Revision    : 1.0 - initial release
// ============================================================================
interface riscv_multiplier_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) ();

  logic              opcode_valid_i;
  logic [31:0]       opcode_opcode_i;
  logic [TAG_W-1:0]  opcode_rd_idx_i;
  logic [XLEN-1:0]   opcode_ra_operand_i;
  logic [XLEN-1:0]   opcode_rb_operand_i;
  logic              hold_i;
  logic              flush_i;
  logic              writeback_valid_o;
  logic [TAG_W-1:0]  writeback_rd_idx_o;
  logic [XLEN-1:0]   writeback_value_o;
  logic              busy_o;

  // Issue/execute stage side
  modport master (
    output opcode_valid_i, opcode_opcode_i, opcode_rd_idx_i,
    output opcode_ra_operand_i, opcode_rb_operand_i, hold_i, flush_i,
    input  writeback_valid_o, writeback_rd_idx_o, writeback_value_o, busy_o
  );

  // Multiplier side
  modport slave (
    input  opcode_valid_i, opcode_opcode_i, opcode_rd_idx_i,
    input  opcode_ra_operand_i, opcode_rb_operand_i, hold_i, flush_i,
    output writeback_valid_o, writeback_rd_idx_o, writeback_value_o, busy_o
  );

endinterface
`default_nettype wire

// File: rtl/riscv_multiplier_pipe_mul_core.sv
`default_nettype none
// ============================================================================
// Module      : riscv_mul_core
// Description : Combinational signed (XLEN+1)x(XLEN+1) multiply with LO/HI/W
//               result selection. Kept apart so it can be retimed or swapped
//               for a hard multiplier macro.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_mul_core
  import riscv_multiplier_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   a_i,
  input  logic [XLEN:0]   b_i,
  input  res_sel_e        sel_i,
  output logic [XLEN-1:0] result_o
);

  logic [2*XLEN-1:0] a_wide;
  logic [2*XLEN-1:0] b_wide;
  logic [2*XLEN-1:0] prod;
  logic signed [31:0] w32;

  // Sign-extend to the product width: the low 2*XLEN bits of the modular
  // product equal those of the full signed product, which is all we need.
  always_comb begin
    a_wide   = {{(XLEN-1){a_i[XLEN]}}, a_i};
    b_wide   = {{(XLEN-1){b_i[XLEN]}}, b_i};
    prod     = a_wide * b_wide;
    w32      = prod[31:0];
    result_o = prod[XLEN-1:0];
    case (sel_i)
      SEL_HI:  result_o = prod[2*XLEN-1:XLEN];
      SEL_W:   result_o = XLEN'(w32);
      default: result_o = prod[XLEN-1:0];
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/riscv_multiplier_pipe.sv
`default_nettype none
// ============================================================================
// Module      : riscv_multiplier_pipe
// Description : Pipelined M-extension multiplier (MUL/MULH/MULHSU/MULHU, MULW
//               on RV64) with tag tracking, hold, flush and gated writeback.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_multiplier_pipe
  import riscv_multiplier_pipe_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MULT_STAGES = 2,
  parameter int TAG_W       = 5
) (
  input logic                    clk_i,
  input logic                    rst_i,
  riscv_multiplier_pipe_if.slave bus
);

  if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
    $error("riscv_multiplier_pipe: XLEN must be 32 or 64");
  end
  if (MULT_STAGES < 2 || MULT_STAGES > 4) begin : g_bad_stages
    $error("riscv_multiplier_pipe: MULT_STAGES must be 2..4");
  end

  mul_dec_t        dec;
  logic            accept;
  logic [XLEN:0]   a_ext;
  logic [XLEN:0]   b_ext;
  logic [XLEN-1:0] core_res;

  logic            s1_valid_q, s1_valid_d;
  logic [XLEN:0]   s1_a_q, s1_a_d;
  logic [XLEN:0]   s1_b_q, s1_b_d;
  res_sel_e        s1_sel_q, s1_sel_d;
  logic [TAG_W-1:0] s1_rd_q, s1_rd_d;

  logic [MULT_STAGES:2] st_valid_q, st_valid_d;
  logic [TAG_W-1:0]     st_rd_q  [MULT_STAGES:2];
  logic [TAG_W-1:0]     st_rd_d  [MULT_STAGES:2];
  logic [XLEN-1:0]      st_res_q [MULT_STAGES:2];
  logic [XLEN-1:0]      st_res_d [MULT_STAGES:2];

  // Entry k feeds stage k+1: entry 1 is stage 1 plus the multiplier output
  logic [MULT_STAGES-1:1] src_valid;
  logic [TAG_W-1:0]       src_rd  [MULT_STAGES-1:1];
  logic [XLEN-1:0]        src_res [MULT_STAGES-1:1];

  // Decode, accept qualification and operand extension to XLEN+1 bits
  always_comb begin
    dec    = mul_decode(bus.opcode_opcode_i, XLEN == 64);
    accept = bus.opcode_valid_i & dec.ok & ~bus.hold_i & ~bus.flush_i;
    a_ext  = {dec.sgn_a & bus.opcode_ra_operand_i[XLEN-1], bus.opcode_ra_operand_i};
    b_ext  = {dec.sgn_b & bus.opcode_rb_operand_i[XLEN-1], bus.opcode_rb_operand_i};
  end

  // Stage 1: flush clears, hold retains, otherwise load the op or a bubble
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_sel_d   = s1_sel_q;
    s1_rd_d    = s1_rd_q;
    if (bus.flush_i || (!bus.hold_i && !accept)) begin
      s1_valid_d = 1'b0;
      s1_a_d     = '0;
      s1_b_d     = '0;
      s1_sel_d   = SEL_LO;
      s1_rd_d    = '0;
    end else if (!bus.hold_i) begin
      s1_valid_d = 1'b1;
      s1_a_d     = a_ext;
      s1_b_d     = b_ext;
      s1_sel_d   = dec.sel;
      s1_rd_d    = bus.opcode_rd_idx_i;
    end
  end

  riscv_mul_core #(
    .XLEN (XLEN)
  ) u_mul_core (
    .a_i      (s1_a_q),
    .b_i      (s1_b_q),
    .sel_i    (s1_sel_q),
    .result_o (core_res)
  );

  // Result stages 2..MULT_STAGES: shift forward unless held or flushed
  always_comb begin
    src_valid[1] = s1_valid_q;
    src_rd[1]    = s1_rd_q;
    src_res[1]   = core_res;
    for (int k = 2; k < MULT_STAGES; k++) begin
      src_valid[k] = st_valid_q[k];
      src_rd[k]    = st_rd_q[k];
      src_res[k]   = st_res_q[k];
    end
    st_valid_d = st_valid_q;
    st_rd_d    = st_rd_q;
    st_res_d   = st_res_q;
    for (int k = 2; k <= MULT_STAGES; k++) begin
      if (bus.flush_i) begin
        st_valid_d[k] = 1'b0;
        st_rd_d[k]    = '0;
        st_res_d[k]   = '0;
      end else if (!bus.hold_i) begin
        st_valid_d[k] = src_valid[k-1];
        st_rd_d[k]    = src_rd[k-1];
        st_res_d[k]   = src_res[k-1];
      end
    end
  end

  // Pipeline registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_sel_q   <= SEL_LO;
      s1_rd_q    <= '0;
      st_valid_q <= '0;
      for (int k = 2; k <= MULT_STAGES; k++) begin
        st_rd_q[k]  <= '0;
        st_res_q[k] <= '0;
      end
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_sel_q   <= s1_sel_d;
      s1_rd_q    <= s1_rd_d;
      st_valid_q <= st_valid_d;
      st_rd_q    <= st_rd_d;
      st_res_q   <= st_res_d;
    end
  end

  assign bus.writeback_valid_o  = st_valid_q[MULT_STAGES];
  assign bus.writeback_rd_idx_o = st_valid_q[MULT_STAGES] ? st_rd_q[MULT_STAGES]  : '0;
  assign bus.writeback_value_o  = st_valid_q[MULT_STAGES] ? st_res_q[MULT_STAGES] : '0;
  assign bus.busy_o             = s1_valid_q | (|st_valid_q);

endmodule
`default_nettype wire

// File: tb/tb_riscv_multiplier_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_multiplier_pipe
// Description : Self-checking bench for riscv_multiplier_pipe covering three
//               configurations (RV32/2 stages, RV32/4 stages, RV64/2 stages).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_multiplier_pipe;

  localparam logic [6:0] OP   = 7'b0110011;
  localparam logic [6:0] OP32 = 7'b0111011;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  riscv_multiplier_pipe_if #(.XLEN(32), .TAG_W(5)) ifa ();
  riscv_multiplier_pipe_if #(.XLEN(32), .TAG_W(5)) ifb ();
  riscv_multiplier_pipe_if #(.XLEN(64), .TAG_W(5)) ifc ();

  riscv_multiplier_pipe #(.XLEN(32), .MULT_STAGES(2), .TAG_W(5)) dut_a (
    .clk_i (clk), .rst_i (rst_n), .bus (ifa));
  riscv_multiplier_pipe #(.XLEN(32), .MULT_STAGES(4), .TAG_W(5)) dut_b (
    .clk_i (clk), .rst_i (rst_n), .bus (ifb));
  riscv_multiplier_pipe #(.XLEN(64), .MULT_STAGES(2), .TAG_W(5)) dut_c (
    .clk_i (clk), .rst_i (rst_n), .bus (ifc));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] enc(input logic [6:0] op, input logic [2:0] f3);
    return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, op};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    ifa.opcode_valid_i      = 1'b1;
    ifa.opcode_opcode_i     = enc(op, f3);
    ifa.opcode_ra_operand_i = a;
    ifa.opcode_rb_operand_i = b;
    ifa.opcode_rd_idx_i     = rd;
  endtask

  task automatic drive_b(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    ifb.opcode_valid_i      = 1'b1;
    ifb.opcode_opcode_i     = enc(OP, 3'b000);
    ifb.opcode_ra_operand_i = a;
    ifb.opcode_rb_operand_i = b;
    ifb.opcode_rd_idx_i     = rd;
  endtask

  task automatic drive_c(input logic [6:0] op, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
    ifc.opcode_valid_i      = 1'b1;
    ifc.opcode_opcode_i     = enc(op, f3);
    ifc.opcode_ra_operand_i = a;
    ifc.opcode_rb_operand_i = b;
    ifc.opcode_rd_idx_i     = rd;
  endtask

  // Scoreboard for back-to-back traffic on dut_a
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;
  bit   sb_en = 1'b0;

  always @(negedge clk) begin
    if (sb_en && ifa.writeback_valid_o) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: got valid rd %0d value %0h expected no result",
                 ifa.writeback_rd_idx_o, ifa.writeback_value_o);
      end else begin
        sb_e = sb_q.pop_front();
        chk("sb_value", 64'(ifa.writeback_value_o), 64'(sb_e.val));
        chk("sb_rd", 64'(ifa.writeback_rd_idx_o), 64'(sb_e.rd));
        chk("sb_cycle", 64'(cyc), 64'(sb_e.cyc));
      end
    end
  end

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [10];

  initial begin
    vt[0] = '{OP, 3'b001, 32'hFFFF_FFFE, 32'd3,        5'd1,  32'hFFFF_FFFF};
    vt[1] = '{OP, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE};
    vt[2] = '{OP, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF};
    vt[3] = '{OP, 3'b000, 32'd7,         32'd6,        5'd4,  32'h0000_002A};
    vt[4] = '{OP, 3'b000, 32'h8000_0000, 32'd2,        5'd5,  32'h0000_0000};
    vt[5] = '{OP, 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000};
    vt[6] = '{OP, 3'b011, 32'h8000_0000, 32'd2,        5'd7,  32'h0000_0001};
    vt[7] = '{OP, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'h0000_0001};
    vt[8] = '{OP, 3'b001, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd9,  32'h3FFF_FFFF};
    vt[9] = '{OP, 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000};

    rst_n = 1'b0;
    ifa.opcode_valid_i = 0; ifa.opcode_opcode_i = 0; ifa.opcode_rd_idx_i = 0;
    ifa.opcode_ra_operand_i = 0; ifa.opcode_rb_operand_i = 0; ifa.hold_i = 0; ifa.flush_i = 0;
    ifb.opcode_valid_i = 0; ifb.opcode_opcode_i = 0; ifb.opcode_rd_idx_i = 0;
    ifb.opcode_ra_operand_i = 0; ifb.opcode_rb_operand_i = 0; ifb.hold_i = 0; ifb.flush_i = 0;
    ifc.opcode_valid_i = 0; ifc.opcode_opcode_i = 0; ifc.opcode_rd_idx_i = 0;
    ifc.opcode_ra_operand_i = 0; ifc.opcode_rb_operand_i = 0; ifc.hold_i = 0; ifc.flush_i = 0;
    repeat (2) tick();
    rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_a_valid", 64'(ifa.writeback_valid_o), 64'd0);
    chk("rst_a_value", 64'(ifa.writeback_value_o), 64'd0);
    chk("rst_a_rd", 64'(ifa.writeback_rd_idx_o), 64'd0);
    chk("rst_a_busy", 64'(ifa.busy_o), 64'd0);
    chk("rst_b_busy", 64'(ifb.busy_o), 64'd0);
    chk("rst_c_valid", 64'(ifc.writeback_valid_o), 64'd0);

    // Single MUL 7x6 with exact two-cycle latency
    tick();
    drive_a(OP, 3'b000, 32'd7, 32'd6, 5'd3);
    tick();
    ifa.opcode_valid_i = 1'b0;
    @(negedge clk);
    chk("mul1_c1_valid", 64'(ifa.writeback_valid_o), 64'd0);
    chk("mul1_c1_busy", 64'(ifa.busy_o), 64'd1);
    @(negedge clk);
    chk("mul1_c2_valid", 64'(ifa.writeback_valid_o), 64'd1);
    chk("mul1_c2_rd", 64'(ifa.writeback_rd_idx_o), 64'd3);
    chk("mul1_c2_value", 64'(ifa.writeback_value_o), 64'h2A);
    @(negedge clk);
    chk("mul1_c3_valid", 64'(ifa.writeback_valid_o), 64'd0);
    chk("mul1_c3_value", 64'(ifa.writeback_value_o), 64'd0);
    chk("mul1_c3_rd", 64'(ifa.writeback_rd_idx_o), 64'd0);
    chk("mul1_c3_busy", 64'(ifa.busy_o), 64'd0);

    // Table vectors issued back-to-back, checked by the scoreboard
    tick();
    sb_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_a(vt[i].op, vt[i].f3, vt[i].a, vt[i].b, vt[i].rd);
      sb_q.push_back('{vt[i].rd, vt[i].exp, cyc + 2});
      tick();
    end
    ifa.opcode_valid_i = 1'b0;
    repeat (5) tick();
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    sb_en = 1'b0;

    // MULW is not a legal encoding on RV32
    drive_a(OP32, 3'b000, 32'h7FFF_FFFF, 32'd2, 5'd4);
    tick();
    ifa.opcode_valid_i = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("mulw32_valid", 64'(ifa.writeback_valid_o), 64'd0);
      if (c == 1) chk("mulw32_busy", 64'(ifa.busy_o), 64'd0);
    end

    // Hold on the 4-stage pipe: three held edges push the result to cycle 7
    tick();
    drive_b(32'd5, 32'd5, 5'd7);
    tick();
    ifb.opcode_valid_i = 1'b0;
    ifb.hold_i = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk("hold_valid", 64'(ifb.writeback_valid_o), (c == 7) ? 64'd1 : 64'd0);
      chk("hold_value", 64'(ifb.writeback_value_o), (c == 7) ? 64'd25 : 64'd0);
      chk("hold_rd", 64'(ifb.writeback_rd_idx_o), (c == 7) ? 64'd7 : 64'd0);
      chk("hold_busy", 64'(ifb.busy_o), (c <= 7) ? 64'd1 : 64'd0);
      if (c == 4) ifb.hold_i = 1'b0;
    end

    // Flush with hold and a new op presented: nothing ever writes back
    tick();
    drive_a(OP, 3'b000, 32'd3, 32'd3, 5'd11);
    tick();
    drive_a(OP, 3'b000, 32'd4, 32'd4, 5'd12);
    ifa.flush_i = 1'b1;
    ifa.hold_i  = 1'b1;
    @(negedge clk);
    chk("flush_c1_busy", 64'(ifa.busy_o), 64'd1);
    tick();
    ifa.opcode_valid_i = 1'b0;
    ifa.flush_i = 1'b0;
    ifa.hold_i  = 1'b0;
    for (int c = 2; c <= 6; c++) begin
      @(negedge clk);
      chk("flush_valid", 64'(ifa.writeback_valid_o), 64'd0);
      if (c == 2) chk("flush_busy", 64'(ifa.busy_o), 64'd0);
    end

    // RV64: MULW sign-extends the low word
    tick();
    drive_c(OP32, 3'b000, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'd9);
    tick();
    ifc.opcode_valid_i = 1'b0;
    @(negedge clk);
    chk("mulw_c1_valid", 64'(ifc.writeback_valid_o), 64'd0);
    @(negedge clk);
    chk("mulw_c2_valid", 64'(ifc.writeback_valid_o), 64'd1);
    chk("mulw_c2_value", ifc.writeback_value_o, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("mulw_c2_rd", 64'(ifc.writeback_rd_idx_o), 64'd9);

    // RV64 MULHU of all-ones operands
    tick();
    drive_c(OP, 3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd13);
    tick();
    ifc.opcode_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mulhu64_valid", 64'(ifc.writeback_valid_o), 64'd1);
    chk("mulhu64_value", ifc.writeback_value_o, 64'hFFFF_FFFF_FFFF_FFFE);

    // DIV encoding is rejected
    tick();
    drive_c(OP, 3'b100, 64'd100, 64'd5, 5'd14);
    tick();
    ifc.opcode_valid_i = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("div_valid", 64'(ifc.writeback_valid_o), 64'd0);
      if (c == 1) chk("div_busy", 64'(ifc.busy_o), 64'd0);
    end

    // Reset with two ops in flight on the 4-stage pipe
    tick();
    drive_b(32'd2, 32'd3, 5'd20);
    tick();
    drive_b(32'd4, 32'd5, 5'd21);
    tick();
    ifb.opcode_valid_i = 1'b0;
    @(negedge clk);
    chk("rstfl_c2_busy", 64'(ifb.busy_o), 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int c = 3; c <= 8; c++) begin
      @(negedge clk);
      chk("rstfl_valid", 64'(ifb.writeback_valid_o), 64'd0);
      chk("rstfl_value", 64'(ifb.writeback_value_o), 64'd0);
      chk("rstfl_rd", 64'(ifb.writeback_rd_idx_o), 64'd0);
      chk("rstfl_busy", 64'(ifb.busy_o), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
